// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pipeline register chain with stall, flush-to-bubble, debug freeze and stage readback.
// Optional retired-entry counter is built only when PIPE_RETIRE_CNT_EN is defined.

module pipe_stage_reg #(
    parameter int NB_DATA = 32,
    parameter int NB_CTRL = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_advance,
    input  logic               i_squash,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    input  logic [NB_CTRL-1:0] i_ctrl,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_data,
    output logic [NB_CTRL-1:0] o_ctrl
);
    logic               valid_q, valid_d;
    logic [NB_DATA-1:0] data_q,  data_d;
    logic [NB_CTRL-1:0] ctrl_q,  ctrl_d;

    // Squash clears valid and ctrl together so a bubble never carries write-enables.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (i_squash) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (i_advance) begin
            valid_d = i_valid;
            data_d  = i_data;
            ctrl_d  = i_ctrl;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_ctrl  = ctrl_q;
endmodule

module pipe_stage_chain #(
    parameter int NB_DATA = 32,
    parameter int NB_CTRL = 4,
    parameter int DEPTH   = 2,
    parameter int NB_SEL  = 3,
    parameter int NB_CNT  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dunit_clk_en,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_SEL-1:0]  i_dbg_sel,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_data,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic               o_dbg_valid,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic [NB_CTRL-1:0] o_dbg_ctrl,
    output logic [NB_CNT-1:0]  o_retire_cnt
);
    logic advance;
    logic squash;

    assign advance = i_dunit_clk_en & ~i_stall & ~i_flush;
    assign squash  = i_dunit_clk_en & i_flush;

    // Index 0 is the chain input; index k+1 is the output of stage k.
    logic [DEPTH:0]              vld_pipe;
    logic [DEPTH:0][NB_DATA-1:0] data_pipe;
    logic [DEPTH:0][NB_CTRL-1:0] ctrl_pipe;

    assign vld_pipe[0]  = i_valid;
    assign data_pipe[0] = i_data;
    assign ctrl_pipe[0] = i_valid ? i_ctrl : '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage_reg #(
            .NB_DATA (NB_DATA),
            .NB_CTRL (NB_CTRL)
        ) u_stage (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_advance (advance),
            .i_squash  (squash),
            .i_valid   (vld_pipe[g]),
            .i_data    (data_pipe[g]),
            .i_ctrl    (ctrl_pipe[g]),
            .o_valid   (vld_pipe[g+1]),
            .o_data    (data_pipe[g+1]),
            .o_ctrl    (ctrl_pipe[g+1])
        );
    end

    assign o_valid = vld_pipe[DEPTH];
    assign o_data  = data_pipe[DEPTH];
    assign o_ctrl  = ctrl_pipe[DEPTH];

    // Out-of-range selects fall through to zero.
    always_comb begin
        o_dbg_valid = 1'b0;
        o_dbg_data  = '0;
        o_dbg_ctrl  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_dbg_sel == NB_SEL'(k)) begin
                o_dbg_valid = vld_pipe[k+1];
                o_dbg_data  = data_pipe[k+1];
                o_dbg_ctrl  = ctrl_pipe[k+1];
            end
        end
    end

`ifdef PIPE_RETIRE_CNT_EN
    logic [NB_CNT-1:0] cnt_q, cnt_d;

    // Only entries shifted out of the last stage count; squashed ones do not.
    always_comb begin
        cnt_d = cnt_q;
        if (advance && vld_pipe[DEPTH] && (cnt_q != {NB_CNT{1'b1}}))
            cnt_d = cnt_q + NB_CNT'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign o_retire_cnt = cnt_q;
`else
    assign o_retire_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (DEPTH=2, NB_CNT=3): scoreboard queue for retiring entries
// plus directed checks of latency, stall, flush, freeze, debug readback and counter.

module tb_pipe_stage_chain;
    localparam int NB_DATA = 32;
    localparam int NB_CTRL = 4;
    localparam int DEPTH   = 2;
    localparam int NB_SEL  = 3;
    localparam int NB_CNT  = 3;

    logic               gclk = 1'b0;
    logic               i_reset, i_dunit_clk_en, i_stall, i_flush, i_valid;
    logic [NB_DATA-1:0] i_data;
    logic [NB_CTRL-1:0] i_ctrl;
    logic [NB_SEL-1:0]  i_dbg_sel;
    logic               o_valid, o_dbg_valid;
    logic [NB_DATA-1:0] o_data, o_dbg_data;
    logic [NB_CTRL-1:0] o_ctrl, o_dbg_ctrl;
    logic [NB_CNT-1:0]  o_retire_cnt;

    typedef struct packed {
        logic [NB_DATA-1:0] data;
        logic [NB_CTRL-1:0] ctrl;
    } entry_t;

    entry_t exp_q[$];
    int     tests = 0;
    int     fails = 0;
    logic   adv_prev = 1'b0;

    always #5 gclk = ~gclk;

    pipe_stage_chain #(
        .NB_DATA (NB_DATA), .NB_CTRL (NB_CTRL), .DEPTH (DEPTH),
        .NB_SEL  (NB_SEL),  .NB_CNT  (NB_CNT)
    ) dut (
        .i_clk          (gclk),
        .i_reset        (i_reset),
        .i_dunit_clk_en (i_dunit_clk_en),
        .i_stall        (i_stall),
        .i_flush        (i_flush),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_ctrl         (i_ctrl),
        .i_dbg_sel      (i_dbg_sel),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .o_ctrl         (o_ctrl),
        .o_dbg_valid    (o_dbg_valid),
        .o_dbg_data     (o_dbg_data),
        .o_dbg_ctrl     (o_dbg_ctrl),
        .o_retire_cnt   (o_retire_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected counter value: the counter only exists when the macro is defined.
    function automatic logic [63:0] cnt_exp(input int n);
`ifdef PIPE_RETIRE_CNT_EN
        return 64'(n);
`else
        return 64'(n * 0);
`endif
    endfunction

    // An entry is newly presented when the previous edge advanced and o_valid is now high.
    always @(posedge gclk)
        adv_prev <= ~i_reset & i_dunit_clk_en & ~i_stall & ~i_flush;

    always @(negedge gclk) begin
        if (adv_prev && o_valid) begin
            entry_t e;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_out", {32'h0, o_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 64'(o_data), 64'(e.data));
                chk("sb_ctrl", 64'(o_ctrl), 64'(e.ctrl));
            end
        end
    end

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic issue(input logic [NB_DATA-1:0] d, input logic [NB_CTRL-1:0] c);
        i_valid = 1'b1;
        i_data  = d;
        i_ctrl  = c;
        exp_q.push_back('{data: d, ctrl: c});
        tick();
    endtask

    initial begin
        i_reset = 1'b1; i_dunit_clk_en = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        i_valid = 1'b0; i_data = '0; i_ctrl = '0; i_dbg_sel = '0;
        tick(); tick();
        i_reset = 1'b0;
        chk("rst_o_valid", 64'(o_valid), 0);
        chk("rst_o_data",  64'(o_data), 0);
        chk("rst_o_ctrl",  64'(o_ctrl), 0);
        chk("rst_dbg_valid", 64'(o_dbg_valid), 0);
        chk("rst_dbg_data",  64'(o_dbg_data), 0);
        chk("rst_cnt", 64'(o_retire_cnt), 0);

        // Latency of exactly DEPTH edges, followed by a bubble carrying ctrl=F.
        issue(32'hA5A5_0001, 4'hF);
        chk("lat1_o_valid", 64'(o_valid), 0);
        i_valid = 1'b0; i_data = 32'h0000_DEAD; i_ctrl = 4'hF;
        tick();
        chk("lat2_o_valid", 64'(o_valid), 1);
        chk("lat2_o_data",  64'(o_data), 64'hA5A5_0001);
        chk("lat2_o_ctrl",  64'(o_ctrl), 64'hF);
        chk("lat2_cnt", 64'(o_retire_cnt), 0);
        chk("bub_dbg_valid", 64'(o_dbg_valid), 0);
        chk("bub_dbg_ctrl",  64'(o_dbg_ctrl), 0);
        chk("bub_dbg_data",  64'(o_dbg_data), 64'h0000_DEAD);
        i_ctrl = 4'h0;
        tick();
        chk("ret1_cnt", 64'(o_retire_cnt), cnt_exp(1));
        chk("bub_o_valid", 64'(o_valid), 0);
        chk("bub_o_ctrl",  64'(o_ctrl), 0);
        tick();
        chk("bub_cnt", 64'(o_retire_cnt), cnt_exp(1));

        // Stall with two entries in flight.
        issue(32'h11, 4'h1);
        issue(32'h22, 4'h2);
        i_valid = 1'b0; i_stall = 1'b1; i_dbg_sel = 3'd0;
        for (int i = 0; i < 3; i++) begin
            i_data = 32'h900 + 32'(i);
            tick();
            chk("stall_o_data",   64'(o_data), 64'h11);
            chk("stall_o_valid",  64'(o_valid), 1);
            chk("stall_dbg_data", 64'(o_dbg_data), 64'h22);
            chk("stall_cnt", 64'(o_retire_cnt), cnt_exp(1));
        end
        i_stall = 1'b0;
        tick();
        chk("unstall_o_data", 64'(o_data), 64'h22);
        chk("unstall_cnt", 64'(o_retire_cnt), cnt_exp(2));
        tick();
        chk("unstall_o_valid", 64'(o_valid), 0);
        chk("unstall_cnt2", 64'(o_retire_cnt), cnt_exp(3));

        // Flush together with stall while both stages are valid.
        issue(32'h33, 4'h3);
        issue(32'h44, 4'h4);
        i_valid = 1'b1; i_data = 32'h55; i_ctrl = 4'h5;
        i_stall = 1'b1; i_flush = 1'b1; i_dbg_sel = 3'd1;
        tick();
        exp_q.delete();
        i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_o_valid", 64'(o_valid), 0);
        chk("flush_o_ctrl",  64'(o_ctrl), 0);
        chk("flush_dbg1_data", 64'(o_dbg_data), 64'h33);
        chk("flush_dbg1_ctrl", 64'(o_dbg_ctrl), 0);
        i_dbg_sel = 3'd0;
        #1;
        chk("flush_dbg0_valid", 64'(o_dbg_valid), 0);
        chk("flush_dbg0_data",  64'(o_dbg_data), 64'h44);
        chk("flush_cnt", 64'(o_retire_cnt), cnt_exp(3));

        // Freeze with toggling inputs, out-of-range select, then reset mid-freeze.
        issue(32'h66, 4'h6);
        i_dunit_clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_valid = i[0]; i_stall = i[1]; i_flush = i[0];
            i_data = 32'hC0 + 32'(i); i_ctrl = 4'(i + 7);
            tick();
            chk("frz_dbg_valid", 64'(o_dbg_valid), 1);
            chk("frz_dbg_data",  64'(o_dbg_data), 64'h66);
            chk("frz_dbg_ctrl",  64'(o_dbg_ctrl), 64'h6);
            chk("frz_o_valid",   64'(o_valid), 0);
            chk("frz_o_data",    64'(o_data), 64'h44);
            chk("frz_cnt", 64'(o_retire_cnt), cnt_exp(3));
        end
        i_dbg_sel = 3'd5;
        #1;
        chk("sel5_valid", 64'(o_dbg_valid), 0);
        chk("sel5_data",  64'(o_dbg_data), 0);
        chk("sel5_ctrl",  64'(o_dbg_ctrl), 0);
        i_reset = 1'b1; i_stall = 1'b1; i_flush = 1'b1;
        tick();
        exp_q.delete();
        i_dbg_sel = 3'd0;
        #1;
        chk("rstfrz_o_data",   64'(o_data), 0);
        chk("rstfrz_dbg_data", 64'(o_dbg_data), 0);
        chk("rstfrz_dbg_valid", 64'(o_dbg_valid), 0);
        chk("rstfrz_cnt", 64'(o_retire_cnt), 0);
        i_reset = 1'b0; i_dunit_clk_en = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        tick();

        // Nine back-to-back retirements saturate a 3-bit counter at 7.
        for (int i = 0; i < 9; i++) issue(32'h100 + 32'(i), 4'(i + 1));
        i_valid = 1'b0;
        chk("sat_mid_cnt", 64'(o_retire_cnt), cnt_exp(7));
        tick(); tick(); tick();
        chk("sat_cnt", 64'(o_retire_cnt), cnt_exp(7));
        chk("sb_drained", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
